// File: rtl/disp_sched.sv
// disp_sched: round-robin sharing of the serial 7-segment display path with periodic refresh.
// Define DISP_PRIO_EN to give requester 0 fixed top priority over a round-robin of 1-3.
module disp_sched #(
  parameter int unsigned REFRESH_CYC = 50000000,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [127:0] hexs_in,
  input  logic [3:0]   text_in,
  input  logic [31:0]  point_in,
  input  logic [31:0]  les_in,
  input  logic         p2s_done,
  output logic [3:0]   gnt,
  output logic         start,
  output logic [31:0]  hexs,
  output logic         text,
  output logic [7:0]   point,
  output logic [7:0]   les,
  output logic [1:0]   owner,
  output logic         busy,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
  localparam logic [31:0] RF_LIM = REFRESH_CYC - 1;
  localparam logic [31:0] TO_LIM = (TIMEOUT_CYC == 0) ? 32'd0 : TIMEOUT_CYC - 1;
  state_t state, state_nx;
  logic [1:0] ptr, sel, sel_q;
  logic [3:0] cand;
  logic [31:0] rcnt, tcnt;
  logic refresh, any_req, refresh_hit, timeout_hit, xfer_end;
`ifdef DISP_PRIO_EN
  assign cand = req[0] ? 4'b0001 : (req & 4'b1110);
`else
  assign cand = req;
`endif
  assign any_req = |req;
  assign refresh_hit = (REFRESH_CYC != 0) && (rcnt == RF_LIM);
  assign timeout_hit = tcnt >= TO_LIM;
  assign xfer_end = p2s_done || timeout_hit;
  // first candidate at or after the pointer, wrapping mod 4
  always_comb begin
    sel = ptr;
    for (int i = 3; i >= 0; i--)
      if (cand[ptr + 2'(i)]) sel = ptr + 2'(i);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = (any_req || refresh_hit) ? LOAD : IDLE;
      LOAD:  state_nx = START;
      START: state_nx = WAIT;
      WAIT:  state_nx = xfer_end ? IDLE : WAIT;
    endcase
  end
  always_comb begin
    start = state == START;
    busy  = state != IDLE;
    gnt   = (state == WAIT && p2s_done && !refresh && req[owner]) ? 4'b0001 << owner : 4'b0000;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ptr     <= '0;
      sel_q   <= '0;
      refresh <= 1'b0;
      rcnt    <= '0;
      tcnt    <= '0;
      hexs    <= '0;
      text    <= 1'b0;
      point   <= '0;
      les     <= '0;
      owner   <= '0;
      err     <= 1'b0;
    end else begin
      if (state == IDLE) begin
        rcnt    <= (any_req || refresh_hit) ? 32'd0 : (&rcnt ? rcnt : rcnt + 1'b1);
        sel_q   <= any_req ? sel : owner;
        refresh <= !any_req;
      end
      if (state == LOAD) begin
        hexs  <= hexs_in[{sel_q, 5'b0} +: 32];
        text  <= text_in[sel_q];
        point <= point_in[{sel_q, 3'b0} +: 8];
        les   <= les_in[{sel_q, 3'b0} +: 8];
        owner <= sel_q;
      end
      if (state == START) tcnt <= '0;
      if (state == WAIT) begin
        tcnt <= &tcnt ? tcnt : tcnt + 1'b1;
        if (xfer_end) begin
          ptr <= refresh ? ptr : owner + 2'd1;
          if (!p2s_done) err <= 1'b1;
        end
      end
    end
endmodule
